// File: rtl/lsp_dm_bridge_pkg.sv
// Shared types and constants for the LSP D-mem request bridge.
package lsp_dm_bridge_pkg;

  typedef enum logic [1:0] {
    DMB_IDLE     = 2'd0,
    DMB_BUS_REQ  = 2'd1,
    DMB_BUS_WAIT = 2'd2,
    DMB_RESP     = 2'd3
  } dmb_state_e;

  localparam logic [63:0] DMB_TIMEOUT_DATA = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] DMB_DW_ALIGN     = 64'hFFFF_FFFF_FFFF_FFF8;

endpackage

// File: rtl/lsp_dm_bridge_timeout_ctr.sv
// Clear/enable cycle counter with an expiry flag; LIMIT of 0 never expires.
module dmb_timeout_ctr #(
  parameter int unsigned LIMIT = 1024,
  parameter int unsigned W     = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Expiry is judged on the value the counter is about to reach, so the forced
  // completion lands TIMEOUT_CYCLES cycles after the accept cycle.
  assign expire_o = (LIMIT != 0) && en_i &&
                    ((32'(cnt_q) + 32'd1) >= (LIMIT - 32'd1));

endmodule

// File: rtl/lsp_dm_bridge.sv
// LSP D-mem request to registered valid/ready bus bridge, one outstanding access.
// Optional posted stores: define DMB_POSTED_WRITE_EN.
module lsp_dm_bridge
  import lsp_dm_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TCNT_W         = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] lsp_dm_req_addr,
  input  logic [63:0] lsp_dm_req_wdata,
  input  logic [7:0]  lsp_dm_req_wmask,
  input  logic        lsp_dm_req_wen,
  input  logic        lsp_dm_req_valid,
  output logic        lsp_dm_req_ready,
  output logic [63:0] lsp_dm_resp_rdata,
  output logic        lsp_dm_resp_valid,
  output logic [63:0] bus_req_addr,
  output logic [63:0] bus_req_wdata,
  output logic [7:0]  bus_req_wmask,
  output logic        bus_req_wen,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  input  logic [63:0] bus_resp_rdata,
  input  logic        bus_resp_valid,
  output logic        dm_timeout
);

  dmb_state_e  state_q, state_d;
  logic        accept, active, handshake, resp_hit, expire, timed_out;
  logic        wr_posted, post_now;
  logic        resp_fire_d, timeout_d;
  logic [63:0] rdata_d;

  logic [63:0] bus_addr_q, bus_wdata_q, rdata_q;
  logic [7:0]  bus_wmask_q;
  logic        bus_wen_q, bus_valid_q, resp_valid_q, timeout_q;

  assign accept    = lsp_dm_req_valid && lsp_dm_req_ready;
  assign active    = (state_q == DMB_BUS_REQ) || (state_q == DMB_BUS_WAIT);
  assign handshake = (state_q == DMB_BUS_REQ) && bus_valid_q && bus_req_ready;
  assign resp_hit  = (state_q == DMB_BUS_WAIT) && bus_resp_valid;
  assign timed_out = expire && !resp_hit;

  dmb_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES),
    .W     (TCNT_W)
  ) u_tmo (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (accept),
    .en_i     (active),
    .expire_o (expire)
  );

`ifdef DMB_POSTED_WRITE_EN
  logic wr_posted_q;
  always_ff @(posedge clk) begin
    if (rst)                       wr_posted_q <= 1'b0;
    else if (accept)               wr_posted_q <= lsp_dm_req_wen;
    else if (state_d == DMB_IDLE)  wr_posted_q <= 1'b0;
  end
  assign wr_posted = wr_posted_q;
  assign post_now  = accept && lsp_dm_req_wen;
`else
  assign wr_posted = 1'b0;
  assign post_now  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= DMB_IDLE;
    else     state_q <= state_d;
  end

  // A posted write was already acknowledged, so its completion skips RESP.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DMB_IDLE:     if (accept) state_d = DMB_BUS_REQ;
      DMB_BUS_REQ: begin
        if (timed_out)      state_d = wr_posted ? DMB_IDLE : DMB_RESP;
        else if (handshake) state_d = DMB_BUS_WAIT;
      end
      DMB_BUS_WAIT: if (resp_hit || timed_out) state_d = wr_posted ? DMB_IDLE : DMB_RESP;
      DMB_RESP:     state_d = DMB_IDLE;
      default:      state_d = DMB_IDLE;
    endcase
  end

  always_comb begin
    lsp_dm_req_ready = (state_q == DMB_IDLE) && !rst;
    resp_fire_d      = 1'b0;
    timeout_d        = 1'b0;
    rdata_d          = '0;
    if (post_now) begin
      resp_fire_d = 1'b1;
    end else if (active && (resp_hit || timed_out)) begin
      resp_fire_d = !wr_posted;
      timeout_d   = timed_out;
      if (timed_out)       rdata_d = DMB_TIMEOUT_DATA;
      else if (!bus_wen_q) rdata_d = bus_resp_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_wmask_q  <= '0;
      bus_wen_q    <= 1'b0;
      bus_valid_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      timeout_q    <= 1'b0;
    end else begin
      if (accept) begin
        bus_addr_q  <= lsp_dm_req_addr & DMB_DW_ALIGN;
        bus_wdata_q <= lsp_dm_req_wdata;
        bus_wmask_q <= lsp_dm_req_wen ? lsp_dm_req_wmask : 8'h00;
        bus_wen_q   <= lsp_dm_req_wen;
      end
      bus_valid_q  <= (state_d == DMB_BUS_REQ);
      resp_valid_q <= resp_fire_d;
      timeout_q    <= timeout_d;
      if (resp_fire_d) rdata_q <= rdata_d;
    end
  end

  assign bus_req_addr      = bus_addr_q;
  assign bus_req_wdata     = bus_wdata_q;
  assign bus_req_wmask     = bus_wmask_q;
  assign bus_req_wen       = bus_wen_q;
  assign bus_req_valid     = bus_valid_q;
  assign lsp_dm_resp_valid = resp_valid_q;
  assign lsp_dm_resp_rdata = rdata_q;
  assign dm_timeout        = timeout_q;

endmodule

// File: tb/tb_lsp_dm_bridge.sv
// Directed bench for lsp_dm_bridge with an 8-cycle timeout.
module tb_lsp_dm_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wmask;
  logic        req_wen, req_valid, req_ready;
  logic [63:0] resp_rdata;
  logic        resp_valid;
  logic [63:0] b_addr, b_wdata;
  logic [7:0]  b_wmask;
  logic        b_wen, b_valid, b_ready;
  logic [63:0] b_rdata;
  logic        b_rvalid;
  logic        tmo;

  int n_cmp = 0;
  int n_err = 0;
  int npulse;

  always #5 clk = ~clk;

  lsp_dm_bridge #(
    .TIMEOUT_CYCLES (8),
    .TCNT_W         (4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .lsp_dm_req_addr   (req_addr),
    .lsp_dm_req_wdata  (req_wdata),
    .lsp_dm_req_wmask  (req_wmask),
    .lsp_dm_req_wen    (req_wen),
    .lsp_dm_req_valid  (req_valid),
    .lsp_dm_req_ready  (req_ready),
    .lsp_dm_resp_rdata (resp_rdata),
    .lsp_dm_resp_valid (resp_valid),
    .bus_req_addr      (b_addr),
    .bus_req_wdata     (b_wdata),
    .bus_req_wmask     (b_wmask),
    .bus_req_wen       (b_wen),
    .bus_req_valid     (b_valid),
    .bus_req_ready     (b_ready),
    .bus_resp_rdata    (b_rdata),
    .bus_resp_valid    (b_rvalid),
    .dm_timeout        (tmo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge and tally response pulses.
  task automatic step();
    @(posedge clk);
    #1;
    npulse += int'(resp_valid);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_addr = '0; req_wdata = '0; req_wmask = '0; req_wen = 1'b0;
    req_valid = 1'b0; b_ready = 1'b0; b_rdata = '0; b_rvalid = 1'b0; npulse = 0;
    step();
    chk("rst_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_bus_valid", b_valid, 0);
    chk("rst_timeout", tmo, 0);
    step();
    rst = 1'b0;
    step();
    chk("idle_ready", req_ready, 1);

    // Load, zero-wait bus
    req_valid = 1'b1; req_addr = 64'h8000_0013; req_wen = 1'b0; req_wmask = 8'hFF;
    req_wdata = 64'h5555_5555_5555_5555; b_ready = 1'b1;
    step();
    req_valid = 1'b0;
    chk("ld_bus_valid", b_valid, 1);
    chk("ld_bus_addr", b_addr, 64'h8000_0010);
    chk("ld_bus_wmask", b_wmask, 8'h00);
    chk("ld_bus_wen", b_wen, 0);
    chk("ld_busy", req_ready, 0);
    step();
    b_ready = 1'b0; b_rvalid = 1'b1; b_rdata = 64'h1122_3344_5566_7788;
    chk("ld_c2_resp", resp_valid, 0);
    chk("ld_c2_bus_valid", b_valid, 0);
    step();
    b_rvalid = 1'b0;
    chk("ld_c3_resp", resp_valid, 1);
    chk("ld_c3_rdata", resp_rdata, 64'h1122_3344_5566_7788);
    chk("ld_c3_tmo", tmo, 0);
    chk("ld_c3_ready", req_ready, 0);
    step();
    chk("ld_c4_resp", resp_valid, 0);
    chk("ld_c4_ready", req_ready, 1);

`ifdef DMB_POSTED_WRITE_EN
    // Posted store: early ack, ready held low until the bus write completes
    req_valid = 1'b1; req_addr = 64'h1000_0007; req_wen = 1'b1; req_wmask = 8'h30;
    req_wdata = 64'hABCD_ABCD_ABCD_ABCD; b_ready = 1'b0;
    step();
    req_valid = 1'b0;
    chk("pw_c1_resp", resp_valid, 1);
    chk("pw_c1_rdata", resp_rdata, 0);
    chk("pw_c1_ready", req_ready, 0);
    chk("pw_c1_bus_valid", b_valid, 1);
    step();
    b_ready = 1'b1;
    chk("pw_c2_resp", resp_valid, 0);
    step();
    b_ready = 1'b0; b_rvalid = 1'b1;
    chk("pw_c3_ready", req_ready, 0);
    step();
    b_rvalid = 1'b0;
    chk("pw_c4_ready", req_ready, 1);
    chk("pw_c4_resp", resp_valid, 0);
`else
    // Store with a 5-cycle bus stall; response lands on the expiry cycle and wins
    req_valid = 1'b1; req_addr = 64'h1000_0007; req_wen = 1'b1; req_wmask = 8'h30;
    req_wdata = 64'hABCD_ABCD_ABCD_ABCD; b_ready = 1'b0;
    step();
    req_valid = 1'b0;
    chk("st_bus_addr", b_addr, 64'h1000_0000);
    chk("st_bus_wmask", b_wmask, 8'h30);
    chk("st_bus_wen", b_wen, 1);
    for (int i = 2; i <= 5; i++) begin
      step();
      chk("st_stall_valid", b_valid, 1);
      chk("st_stall_wdata", b_wdata, 64'hABCD_ABCD_ABCD_ABCD);
      chk("st_stall_wmask", b_wmask, 8'h30);
    end
    step();
    b_ready = 1'b1;
    chk("st_c6_valid", b_valid, 1);
    step();
    b_ready = 1'b0; b_rvalid = 1'b1; b_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    chk("st_c7_bus_valid", b_valid, 0);
    chk("st_c7_resp", resp_valid, 0);
    step();
    b_rvalid = 1'b0;
    chk("st_c8_resp", resp_valid, 1);
    chk("st_c8_rdata", resp_rdata, 0);
    chk("st_c8_tmo", tmo, 0);
    step();
    chk("st_c9_resp", resp_valid, 0);
    chk("st_c9_ready", req_ready, 1);
`endif

    // Timeout: bus never ready
    req_valid = 1'b1; req_addr = 64'h2000_0008; req_wen = 1'b0; b_ready = 1'b0;
    step();
    req_valid = 1'b0;
    for (int i = 2; i <= 7; i++) step();
    chk("to_c7_bus_valid", b_valid, 1);
    chk("to_c7_resp", resp_valid, 0);
    step();
    chk("to_c8_resp", resp_valid, 1);
    chk("to_c8_tmo", tmo, 1);
    chk("to_c8_rdata", resp_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("to_c8_bus_valid", b_valid, 0);
    step();
    b_rvalid = 1'b1; b_rdata = 64'h0123_4567_89AB_CDEF;
    chk("to_c9_resp", resp_valid, 0);
    chk("to_c9_tmo", tmo, 0);
    step();
    b_rvalid = 1'b0;
    chk("to_stray_resp", resp_valid, 0);
    chk("to_stray_ready", req_ready, 1);

    // Back-to-back: valid held high across two loads
    npulse = 0;
    req_valid = 1'b1; req_addr = 64'h4000_0020; req_wen = 1'b0; b_ready = 1'b1;
    step();
    chk("bb_c1_ready", req_ready, 0);
    step();
    b_rvalid = 1'b1; b_rdata = 64'hA1A1_A1A1_A1A1_A1A1;
    step();
    b_rvalid = 1'b0; req_addr = 64'h4000_0031;
    chk("bb_c3_ready", req_ready, 0);
    chk("bb_c3_rdata", resp_rdata, 64'hA1A1_A1A1_A1A1_A1A1);
    step();
    chk("bb_c4_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    chk("bb_c5_bus_valid", b_valid, 1);
    chk("bb_c5_bus_addr", b_addr, 64'h4000_0030);
    step();
    b_ready = 1'b0; b_rvalid = 1'b1; b_rdata = 64'hB2B2_B2B2_B2B2_B2B2;
    step();
    b_rvalid = 1'b0;
    chk("bb_c7_rdata", resp_rdata, 64'hB2B2_B2B2_B2B2_B2B2);
    step();
    step();
    chk("bb_pulses", npulse, 2);

    // Reset while in BUS_WAIT, then a normal load
    npulse = 0;
    req_valid = 1'b1; req_addr = 64'h3000_0005; b_ready = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    b_ready = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rs_bus_valid", b_valid, 0);
    chk("rs_resp", resp_valid, 0);
    step();
    chk("rs_ready", req_ready, 1);
    chk("rs_no_pulse", npulse, 0);
    req_valid = 1'b1; req_addr = 64'h3000_000D; b_ready = 1'b1;
    step();
    req_valid = 1'b0;
    chk("rs_ld_addr", b_addr, 64'h3000_0008);
    step();
    b_ready = 1'b0; b_rvalid = 1'b1; b_rdata = 64'hC3C3_C3C3_C3C3_C3C3;
    step();
    b_rvalid = 1'b0;
    chk("rs_ld_resp", resp_valid, 1);
    chk("rs_ld_rdata", resp_rdata, 64'hC3C3_C3C3_C3C3_C3C3);
    step();
    chk("rs_ld_pulses", npulse, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
